uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Buffered 8N1 UART transmitter: the serializing end of the host UART link, driving the line that the host-side receiver samples. Bytes written by fabric logic are queued in an internal FIFO and shifted out LSB first at the configured baud rate. Each frame is one start bit, eight data bits and one stop bit, with no idle gap between queued frames. Bit timing uses the same prescaler scheme as the UART receiver, so both ends agree on the bit period.

## Interface
- CLOCK_RATE, 50000000, system clock frequency in Hz
- BAUD_RATE, 9600, line rate in bits per second
- PRESCALER, 8, oversample factor shared with the receiver
- FIFO_DEPTH, 16, queue depth in bytes; must be a power of 2 and at least 2
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- tx_byte  in  8  byte to enqueue
- transmit  in  1  enqueue strobe; one byte per cycle while high
- ready  out  1  FIFO not full; combinational from the FIFO count
- overflow  out  1  one-cycle pulse when transmit is high while ready is low
- tx  out  1  serial output; idle high
- is_transmitting  out  1  high while a frame is on the line
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte being shifted

## Operation
- Derived constants:
  - CLOCK_DIVIDE = CLOCK_RATE / (BAUD_RATE * PRESCALER), integer division
  - BIT_PERIOD = PRESCALER * CLOCK_DIVIDE cycles
  - Elaboration fails if CLOCK_DIVIDE < 1.
- Enqueue: on a rising edge with transmit=1 and ready=1, tx_byte is written to the FIFO tail.
- Rejected write: transmit=1 with ready=0 drops the byte and pulses overflow for that cycle. FIFO contents are unchanged.
- Push and pop in the same cycle: fifo_count is unchanged. The push-when-full rejection still applies even if a pop occurs in that cycle.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into shift_reg and go to START.
  - START: tx=0 for BIT_PERIOD cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift_reg[bit_idx] for BIT_PERIOD cycles per bit. After bit 7, go to STOP.
  - STOP: tx=1 for BIT_PERIOD cycles. At the end, if the FIFO is non-empty, pop and go directly to START; otherwise go to IDLE.
- A down-counter of width $clog2(BIT_PERIOD+1) times each bit. It reloads BIT_PERIOD-1 on every state or bit change.
- is_transmitting=1 in START, DATA and STOP, and 0 in IDLE.
- tx is a register output, so it is glitch-free.

## Timing
- Reset values (asynchronous, while rst=0):
  - tx=1, is_transmitting=0, overflow=0, fifo_count=0, ready=1
  - state=IDLE, FIFO pointers cleared
- Reset mid-frame aborts the frame immediately: tx returns high asynchronously and queued bytes are discarded.
- Latency from an idle line: if transmit is accepted at edge N, the pop occurs at edge N+1, and tx falls low and is_transmitting rises after edge N+1.
- Frame length is exactly 10*BIT_PERIOD cycles from tx falling to the STOP bit ending. Each bit lasts exactly BIT_PERIOD cycles, with no stretch.
- Back-to-back frames: the start bit of the next frame begins on the cycle after the last STOP cycle, so the line has no idle cycles between frames.
- fifo_count decrements at the pop edge. ready rises in the same cycle that fifo_count drops below FIFO_DEPTH.
- Capacity: a full FIFO plus one byte in flight gives FIFO_DEPTH+1 bytes accepted before the first overflow, counting from an idle line.

## Structure
- Package uart_pkg:
  - state enum uart_tx_state_t {IDLE, START, DATA, STOP}
  - function computing CLOCK_DIVIDE, shared with the receiver
  - constants FRAME_BITS=10 and DATA_BITS=8
- Sub-module uart_tx_fifo: synchronous FIFO with single-cycle write and pop. It provides full, empty and count, and uses the same asynchronous active-low rst.
- The top level holds the FSM, bit counter and shift register.

## Test plan
All scenarios use CLOCK_RATE=153600, BAUD_RATE=9600 and PRESCALER=8, giving BIT_PERIOD=16 and a 160-cycle frame.
- Single byte 8'hF0 from idle → tx low at N+1 for 16 cycles; data bits 0,0,0,0,1,1,1,1 each 16 cycles; stop high; is_transmitting low after 160 cycles.
- Bytes 8'h01 then 8'h55 on consecutive cycles → two frames with zero idle cycles between them; decoded bits match LSB first; fifo_count sequence 1,1,0.
- 17 writes on consecutive cycles with FIFO_DEPTH=16 → all accepted; ready drops after the 17th; an 18th write pulses overflow once; exactly 17 frames go out.
- Reset asserted in DATA bit 3 of 8'hA5 → tx=1 and fifo_count=0 immediately; no further frames after reset is released.
- Write while full in the same cycle as a pop at STOP end → write rejected, overflow pulsed, fifo_count drops to 15.
- A loopback receiver at the same parameters decodes a 256-byte ramp 8'h00–8'hFF with no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants and the
// prescaler divide used by both ends of the link.
package uart_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  // Integer division, so any remainder is dropped and the bit period rounds down.
  function automatic int clock_divide(input int clock_rate, input int baud_rate,
                                      input int prescaler);
    return clock_rate / (baud_rate * prescaler);
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Fabric-side byte write port of the buffered UART transmitter.
interface uart_tx_buffered_if;
  import uart_pkg::*;

  // Handshake: a byte is taken on any rising edge where transmit and ready are
  // both high. If transmit is high while ready is low, the byte is dropped and
  // overflow is high for that same cycle. ready never waits for transmit.
  logic [DATA_BITS-1:0] tx_byte;
  logic                 transmit;
  logic                 ready;
  logic                 overflow;

  modport master (output tx_byte, output transmit, input ready, input overflow);
  modport slave  (input tx_byte, input transmit, output ready, output overflow);

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte queue in front of the serializer. It takes one push and one pop per cycle,
// and a push to a full queue is ignored even when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // The pointers wrap on their own because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter. Queued bytes go out LSB first, and frames
// run back to back while the queue holds data.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int PRESCALER  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_buffered_if.slave           bus,
  output logic                        tx,
  output logic                        is_transmitting,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output uart_tx_state_t              state
);

  localparam int CLOCK_DIVIDE = clock_divide(CLOCK_RATE, BAUD_RATE, PRESCALER);
  localparam int BIT_PERIOD   = PRESCALER * CLOCK_DIVIDE;
  localparam int CNT_W        = $clog2(BIT_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BIT_PERIOD - 1);
  localparam logic [2:0]       LAST_BIT   = 3'(DATA_BITS - 1);

  if (CLOCK_DIVIDE < 1) begin : g_bad_divide
    $error("uart_tx_buffered: CLOCK_RATE too low for BAUD_RATE * PRESCALER");
  end

  logic [DATA_BITS-1:0] head;
  logic [DATA_BITS-1:0] shift_reg;
  logic [2:0]           bit_idx;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 bit_done;
  logic                 pop;

  assign bit_done     = (bit_cnt == '0);
  assign pop          = !fifo_empty && ((state == IDLE) || (state == STOP && bit_done));
  assign bus.ready    = !fifo_full;
  assign bus.overflow = bus.transmit && fifo_full;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.transmit),
    .push_data (bus.tx_byte),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // bit_cnt counts down the cycles left in the current bit. When a bit ends,
  // tx is loaded with the level of the next bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      tx              <= 1'b1;
      is_transmitting <= 1'b0;
      shift_reg       <= '0;
      bit_idx         <= '0;
      bit_cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state           <= START;
            tx              <= 1'b0;
            is_transmitting <= 1'b1;
            shift_reg       <= head;
            bit_cnt         <= CNT_RELOAD;
          end
        end
        START: begin
          if (bit_done) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift_reg[0];
            bit_cnt <= CNT_RELOAD;
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            bit_cnt <= CNT_RELOAD;
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            if (pop) begin
              state     <= START;
              tx        <= 1'b0;
              shift_reg <= head;
              bit_cnt   <= CNT_RELOAD;
            end else begin
              state           <= IDLE;
              is_transmitting <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered. A frame-level reference model predicts the line
// cycle by cycle, and a loopback receiver checks the decoded bytes against a queue.
`timescale 1ns/1ps
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int CLOCK_RATE = 153600;
  localparam int BAUD_RATE  = 9600;
  localparam int PRESCALER  = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int BIT_PERIOD = PRESCALER * (CLOCK_RATE / (BAUD_RATE * PRESCALER));
  localparam int FRAME      = 10 * BIT_PERIOD;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_buffered_if bus ();
  logic           tx;
  logic           is_tx;
  logic [CW-1:0]  fifo_count;
  uart_tx_state_t dbg_state;

  uart_tx_buffered #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE),
    .PRESCALER  (PRESCALER),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .tx              (tx),
    .is_transmitting (is_tx),
    .fifo_count      (fifo_count),
    .state           (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      if (errors >= 100) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  endtask

  // ---------------- reference model ----------------
  // mq holds queued bytes. busy_left is the number of clock edges left before the
  // line frame in flight ends.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] cur_byte = 8'h00;
  int         busy_left = 0;
  bit         m_acc;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      mq.delete();
      exp_q.delete();
      busy_left = 0;
    end else begin
      m_acc = bus.transmit && (mq.size() < FIFO_DEPTH);
      if (busy_left > 0) busy_left--;
      if (busy_left == 0 && mq.size() > 0) begin
        cur_byte  = mq.pop_front();
        busy_left = FRAME;
      end
      if (m_acc) begin
        mq.push_back(bus.tx_byte);
        exp_q.push_back(bus.tx_byte);
      end
    end
  end

  function automatic logic exp_line();
    int el;
    int k;
    if (busy_left == 0) return 1'b1;
    el = FRAME - busy_left;
    k  = el / BIT_PERIOD;
    if (k == 0) return 1'b0;
    if (k <= DATA_BITS) return cur_byte[k-1];
    return 1'b1;
  endfunction

  // Cycle monitor: checks every output against the model on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst === 1'b1) begin
      check("tx_line", tx, exp_line());
      check("is_transmitting", is_tx, busy_left > 0);
      check("fifo_count", fifo_count, mq.size());
      check("ready", bus.ready, mq.size() < FIFO_DEPTH);
      check("overflow", bus.overflow, bus.transmit && (mq.size() >= FIFO_DEPTH));
    end
  end

  // Loopback receiver: samples each bit at its midpoint and pops the scoreboard.
  bit         rx_busy = 0;
  int         rx_off = 0;
  int         rx_k;
  int         rx_frames = 0;
  logic [7:0] rx_data = 8'h00;

  initial forever begin
    @(negedge clk or negedge rst);
    if (!rst) begin
      rx_busy = 0;
    end else begin
      if (rx_busy) rx_off++;
      else if (tx === 1'b0) begin
        rx_busy = 1;
        rx_off  = 0;
      end
      if (rx_busy && (rx_off % BIT_PERIOD) == BIT_PERIOD / 2) begin
        rx_k = rx_off / BIT_PERIOD;
        if (rx_k == 0) check("rx_start_bit", tx, 1'b0);
        else if (rx_k <= DATA_BITS) rx_data[rx_k-1] = tx;
        else begin
          check("rx_stop_bit", tx, 1'b1);
          rx_frames++;
          check("rx_frame_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) check("rx_byte", rx_data, exp_q.pop_front());
          rx_busy = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.tx_byte  = b;
    bus.transmit = 1'b1;
    step(1);
    bus.transmit = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((busy_left != 0 || mq.size() != 0) && n < budget) begin
      step(1);
      n++;
    end
    check({name, "_drain_in_time"}, n < budget, 1'b1);
    step(4);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int         base;
  int         n;
  logic [8:0] v;

  initial begin
    rst          = 1'b0;
    bus.transmit = 1'b1;
    bus.tx_byte  = 8'h5A;
    step(3);
    check("reset_tx", tx, 1'b1);
    check("reset_is_transmitting", is_tx, 1'b0);
    check("reset_fifo_count", fifo_count, 0);
    check("reset_ready", bus.ready, 1'b1);
    check("reset_overflow", bus.overflow, 1'b0);
    check("reset_state", dbg_state, IDLE);
    bus.transmit = 1'b0;
    rst = 1'b1;
    step(3);

    // Single byte from idle: pop one edge after the write, then a 160-cycle frame
    send(8'hF0);
    check("t1_count_after_push", fifo_count, 1);
    check("t1_tx_still_idle", tx, 1'b1);
    step(1);
    check("t1_tx_start_low", tx, 1'b0);
    check("t1_busy_rises", is_tx, 1'b1);
    check("t1_count_after_pop", fifo_count, 0);
    step(FRAME - 1);
    check("t1_busy_last_stop_cycle", is_tx, 1'b1);
    step(1);
    check("t1_busy_falls", is_tx, 1'b0);
    check("t1_tx_idle_after", tx, 1'b1);
    check("t1_frames", rx_frames, 1);

    // Two back-to-back bytes
    base = rx_frames;
    send(8'h01);
    check("t2_count_a", fifo_count, 1);
    send(8'h55);
    check("t2_count_b", fifo_count, 1);
    wait_drain("t2", 3 * FRAME);
    check("t2_frames", rx_frames - base, 2);

    // Fill: 17 accepted, 18th overflows, then a write rejected at the pop edge
    base = rx_frames;
    for (int i = 0; i < 17; i++) send(8'(8'h10 + i));
    check("t3_count_full", fifo_count, FIFO_DEPTH);
    check("t3_ready_low", bus.ready, 1'b0);
    bus.tx_byte  = 8'hEE;
    bus.transmit = 1'b1;
    #2;
    check("t3_overflow_pulse", bus.overflow, 1'b1);
    step(1);
    bus.transmit = 1'b0;
    #2;
    check("t3_overflow_clears", bus.overflow, 1'b0);
    check("t3_count_unchanged", fifo_count, FIFO_DEPTH);
    n = 0;
    while (busy_left != 1 && n < FRAME + 10) begin
      step(1);
      n++;
    end
    check("t5_reach_stop_end", busy_left, 1);
    bus.tx_byte  = 8'h77;
    bus.transmit = 1'b1;
    #2;
    check("t5_overflow_at_pop", bus.overflow, 1'b1);
    step(1);
    bus.transmit = 1'b0;
    check("t5_count_after_pop", fifo_count, FIFO_DEPTH - 1);
    check("t5_ready_after_pop", bus.ready, 1'b1);
    wait_drain("t3", 18 * FRAME);
    check("t3_frames", rx_frames - base, 17);

    // Reset in DATA bit 3 of 8'hA5 with another byte queued behind it
    send(8'hA5);
    send(8'h3C);
    n = 0;
    while (FRAME - busy_left != 4 * BIT_PERIOD + 6 && n < 2 * FRAME) begin
      step(1);
      n++;
    end
    check("t4_in_data_bit3", dbg_state, DATA);
    check("t4_tx_bit3_low", tx, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("t4_tx_high_async", tx, 1'b1);
    check("t4_count_cleared", fifo_count, 0);
    check("t4_busy_cleared", is_tx, 1'b0);
    check("t4_ready_in_reset", bus.ready, 1'b1);
    base = rx_frames;
    step(3);
    rst = 1'b1;
    step(2 * FRAME);
    check("t4_no_frames_after", rx_frames - base, 0);
    check("t4_line_idle", tx, 1'b1);

    // Random writes, including attempts while full
    base = rx_frames;
    for (int i = 0; i < 600; i++) begin
      bus.transmit = ($urandom_range(0, 3) == 0);
      bus.tx_byte  = 8'($urandom);
      step(1);
    end
    bus.transmit = 1'b0;
    wait_drain("rand", 20 * FRAME);

    // Loopback ramp 0x00..0xFF with random pacing, never writing into a full queue
    base = rx_frames;
    v = 9'd0;
    n = 0;
    while (v < 9'd256 && n < 60000) begin
      if (mq.size() < FIFO_DEPTH && $urandom_range(0, 1) == 1) begin
        bus.tx_byte  = v[7:0];
        bus.transmit = 1'b1;
        v = v + 9'd1;
      end else begin
        bus.transmit = 1'b0;
      end
      step(1);
      n++;
    end
    bus.transmit = 1'b0;
    check("ramp_all_written", v, 9'd256);
    wait_drain("ramp", 20 * FRAME);
    check("ramp_frames", rx_frames - base, 256);
    check("final_scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
